// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// frame_buffer_arbiter : single-port frame-buffer RAM shared between a
//                        fixed-latency VGA reader and a FIFO-buffered writer
// Revision: 1.0
// ============================================================================
module frame_buffer_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          flush,
  input  logic                          clear_status,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_stall
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [1:0]        rd_pipe;
  slot_t             slot;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign wr_ready   = !full;
  assign push       = wr_valid && !full && !flush;
  assign pop        = (slot == SLOT_WRITE);
  assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];

  always_comb begin
    slot = SLOT_IDLE;
    if (rd_req) begin
      slot = SLOT_READ;
    end else if (!empty) begin
      slot = SLOT_WRITE;
    end
  end

  always_ff @(posedge clk25) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= wr_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= wr_data;
    end
  end

  // Flush discards everything queued; a pop decided this cycle has already
  // captured the head into the RAM registers below.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      unique case (slot)
        SLOT_READ: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        SLOT_WRITE: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
          mem_we    <= 1'b1;
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0: address at RAM, stage 1: RAM data on mem_rdata, then capture.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      rd_pipe  <= 2'b00;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], rd_req};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rd_data <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      wr_stall <= 1'b0;
    end else if (wr_valid && full) begin
      wr_stall <= 1'b1;
    end else if (clear_status) begin
      wr_stall <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_level_bound: assert property (@(posedge clk25) disable iff (reset)
    32'(fifo_level) <= FIFO_DEPTH);
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_frame_buffer_arbiter : directed self-checking bench for frame_buffer_arbiter
// Revision: 1.0
// ============================================================================
module tb_frame_buffer_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 16;

  logic              clk25 = 1'b0;
  logic              reset = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              flush = 1'b0;
  logic              clear_status = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [4:0]        fifo_level;
  logic              wr_stall;

  int checks = 0;
  int errors = 0;

  frame_buffer_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk25(clk25), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .clear_status(clear_status),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .wr_stall(wr_stall)
  );

  always #5 clk25 = ~clk25;

  // RAM model: every location reads back its own low address bits.
  always @(posedge clk25) begin
    if (!mem_we) mem_rdata <= mem_addr[11:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; wr_valid = 1'b0; flush = 1'b0; clear_status = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},    32'(fifo_level), 32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready),   32'd1);
    check({tag, "_rd_valid"}, 32'(rd_valid),   32'd0);
    check({tag, "_rd_data"},  32'(rd_data),    32'd0);
    check({tag, "_mem_we"},   32'(mem_we),     32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},32'(mem_wdata),  32'd0);
    check({tag, "_wr_stall"}, 32'(wr_stall),   32'd0);
  endtask

  initial begin
    int lvl;
    int r;
    logic [DATA_W-1:0] last_data;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check_reset_values("reset");
    tick();

    // Reads only, every other cycle, addresses 0..3
    last_data = '0;
    for (int c = 0; c < 12; c++) begin
      rd_req  = (c < 8) && (c % 2 == 0);
      rd_addr = ADDR_W'(c / 2);
      r = c - 3;
      if (r >= 0 && r < 8 && r % 2 == 0) begin
        check("rd_only_valid", 32'(rd_valid), 32'd1);
        check("rd_only_data", 32'(rd_data), 32'(r / 2));
        last_data = DATA_W'(r / 2);
      end else begin
        check("rd_only_idle", 32'(rd_valid), 32'd0);
        check("rd_only_hold", 32'(rd_data), 32'(last_data));
      end
      check("rd_only_we", 32'(mem_we), 32'd0);
      tick();
    end
    idle_inputs();

    // Writes only: five entries drain on five consecutive cycles
    for (int c = 0; c < 9; c++) begin
      wr_valid = (c < 5);
      wr_addr  = ADDR_W'(100 + c);
      wr_data  = DATA_W'(12'hA00 + c);
      lvl = (c >= 1 && c <= 5) ? 1 : 0;
      check("wr_only_level", 32'(fifo_level), 32'(lvl));
      if (c >= 2 && c <= 6) begin
        check("wr_only_we", 32'(mem_we), 32'd1);
        check("wr_only_addr", 32'(mem_addr), 32'(100 + c - 2));
        check("wr_only_wdata", 32'(mem_wdata), 32'(12'hA00 + c - 2));
      end else begin
        check("wr_only_we_idle", 32'(mem_we), 32'd0);
      end
      tick();
    end
    idle_inputs();

    // Contention: reads hold the RAM, FIFO fills, full-with-pop refuses push
    for (int c = 0; c < 40; c++) begin
      rd_req   = (c < 20);
      rd_addr  = ADDR_W'(200 + c);
      wr_valid = (c <= 20);
      wr_addr  = ADDR_W'(300 + c);
      wr_data  = DATA_W'(12'hB00 + c);
      lvl = (c <= 16) ? c : (c <= 20) ? 16 : (c <= 36) ? 36 - c : 0;
      check("cont_level", 32'(fifo_level), 32'(lvl));
      check("cont_wr_ready", 32'(wr_ready), (lvl == 16) ? 32'd0 : 32'd1);
      check("cont_stall", 32'(wr_stall), (c >= 17) ? 32'd1 : 32'd0);
      if (c >= 21 && c <= 36) begin
        check("cont_we", 32'(mem_we), 32'd1);
        check("cont_addr", 32'(mem_addr), 32'(300 + c - 21));
        check("cont_wdata", 32'(mem_wdata), 32'(12'hB00 + c - 21));
      end else begin
        check("cont_we_idle", 32'(mem_we), 32'd0);
      end
      if (c >= 3 && c <= 22) begin
        check("cont_rd_valid", 32'(rd_valid), 32'd1);
        check("cont_rd_data", 32'(rd_data), 32'((200 + c - 3) & 12'hFFF));
      end else begin
        check("cont_rd_idle", 32'(rd_valid), 32'd0);
      end
      tick();
    end
    idle_inputs();

    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("stall_cleared", 32'(wr_stall), 32'd0);
    tick();

    // Flush with 8 queued and a read in the flush cycle
    for (int c = 0; c < 15; c++) begin
      rd_req   = (c <= 8);
      rd_addr  = ADDR_W'(400 + c);
      wr_valid = (c <= 8);
      wr_addr  = ADDR_W'(500 + c);
      wr_data  = DATA_W'(12'hC00 + c);
      flush    = (c == 8);
      check("flush_level", 32'(fifo_level), (c <= 8) ? 32'(c) : 32'd0);
      check("flush_we", 32'(mem_we), 32'd0);
      if (c >= 3 && c <= 11) begin
        check("flush_rd_valid", 32'(rd_valid), 32'd1);
        check("flush_rd_data", 32'(rd_data), 32'((400 + c - 3) & 12'hFFF));
      end else begin
        check("flush_rd_idle", 32'(rd_valid), 32'd0);
      end
      tick();
    end
    idle_inputs();

    // Flush in a cycle that already chose a WRITE slot
    for (int c = 0; c < 6; c++) begin
      rd_req   = (c < 2);
      rd_addr  = ADDR_W'(450);
      wr_valid = (c < 2);
      wr_addr  = ADDR_W'(600 + c);
      wr_data  = DATA_W'(12'hD00 + c);
      flush    = (c == 2);
      check("flwr_we", 32'(mem_we), (c == 3) ? 32'd1 : 32'd0);
      if (c == 2) check("flwr_level_pre", 32'(fifo_level), 32'd2);
      if (c == 3) begin
        check("flwr_level_post", 32'(fifo_level), 32'd0);
        check("flwr_addr", 32'(mem_addr), 32'd600);
        check("flwr_wdata", 32'(mem_wdata), 32'hD00);
      end
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    // Asynchronous reset mid-burst
    for (int c = 0; c < 6; c++) begin
      rd_req   = 1'b1;
      rd_addr  = ADDR_W'(700 + c);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(800 + c);
      wr_data  = DATA_W'(12'hE00 + c);
      tick();
    end
    idle_inputs();
    check("arst_pre_level", 32'(fifo_level), 32'd6);
    check("arst_pre_valid", 32'(rd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("arst");
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("arst_post_valid", 32'(rd_valid), 32'd0);
      check("arst_post_we", 32'(mem_we), 32'd0);
      check("arst_post_level", 32'(fifo_level), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
